// File: rtl/imm_pkg.sv
// Immediate-generator shared types and constants.
//   imm_type_e  : format select encoding on in_imm_type
//   OP_*        : RV32I/RV64I major opcodes recognised by AUTO decode
//   auto_decode : maps an opcode to {known, format}
// The per-entry payload struct depends on XLEN/TAG_W of the instantiating
// module, so it is declared there rather than here.
package imm_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned TYPE_W = 3;

    typedef enum logic [TYPE_W-1:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_AUTO = 3'd7
    } imm_type_e;

    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    // Returns {known, format}; unknown opcodes return IMM_AUTO as format.
    function automatic logic [TYPE_W:0] auto_decode(input logic [OPC_W-1:0] opc);
        logic [TYPE_W:0] r;
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR: r = {1'b1, IMM_I};
            OP_STORE:                 r = {1'b1, IMM_S};
            OP_BRANCH:                r = {1'b1, IMM_B};
            OP_LUI, OP_AUIPC:         r = {1'b1, IMM_U};
            OP_JAL:                   r = {1'b1, IMM_J};
            default:                  r = {1'b0, IMM_AUTO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate generator with AUTO opcode decode.
//   inst      : 32-bit instruction word
//   imm_type  : format select (I/S/B/U/J/AUTO, 5 and 6 reserved)
//   imm_c     : immediate sign-extended to XLEN (zero when illegal)
//   illegal_c : reserved format or unrecognised opcode under AUTO
module imm_gen_core
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    input  logic [TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]   imm_c,
    output logic              illegal_c
);

    logic [TYPE_W-1:0] fmt;
    logic [TYPE_W:0]   dec;
    logic [31:0]       raw;

    always_comb begin
        fmt       = imm_type;
        dec       = auto_decode(inst[OPC_W-1:0]);
        raw       = '0;
        imm_c     = '0;
        illegal_c = 1'b0;

        if (imm_type == IMM_AUTO) begin
            fmt = dec[TYPE_W-1:0];
        end

        // Each format is first built as a sign-extended 32-bit value;
        // the final widening to XLEN extends from bit 31 (RV64 U rule).
        case (fmt)
            IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   raw = {inst[31:12], 12'b0};
            IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: illegal_c = 1'b1;
        endcase

        if (!illegal_c) begin
            imm_c = XLEN'($signed(raw));
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, valid/ready immediate generator with a 2-entry skid buffer.
//   clk, rst_n          : clock, async active-low reset
//   in_val/in_rdy       : request handshake; in_inst, in_imm_type, in_tag
//   out_val/out_rdy     : response handshake; out_imm, out_tag, out_illegal
//   illegal_cnt         : saturating count of accepted illegal requests
// Entry M drives the outputs, entry K catches one request under backpressure.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [31:0]       in_inst,
    input  logic [2:0]        in_imm_type,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t            m_q, m_d, k_q, k_d, new_c;
    logic              m_vld_q, m_vld_d, k_vld_q, k_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_c, drain_c;
    logic [XLEN-1:0]   imm_c;
    logic              illegal_c;

    // Immediate is computed at the input and stored with the request.
    imm_gen_core #(
        .XLEN(XLEN)
    ) u_core (
        .inst      (in_inst),
        .imm_type  (in_imm_type),
        .imm_c     (imm_c),
        .illegal_c (illegal_c)
    );

    assign new_c   = '{imm: imm_c, tag: in_tag, illegal: illegal_c};
    assign acc_c   = in_val && !k_vld_q;
    assign drain_c = m_vld_q && out_rdy;

    // Next-state for the two entries and the illegal counter.
    always_comb begin
        m_d     = m_q;
        k_d     = k_q;
        m_vld_d = m_vld_q;
        k_vld_d = k_vld_q;
        cnt_d   = cnt_q;

        if (!m_vld_q) begin
            if (acc_c) begin
                m_d     = new_c;
                m_vld_d = 1'b1;
            end
        end else if (drain_c) begin
            if (k_vld_q) begin
                // in_rdy is low here, so no accept can race the refill.
                m_d     = k_q;
                k_vld_d = 1'b0;
            end else if (acc_c) begin
                m_d = new_c;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (acc_c) begin
            k_d     = new_c;
            k_vld_d = 1'b1;
        end

        if (acc_c && illegal_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            k_q     <= '0;
            m_vld_q <= 1'b0;
            k_vld_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            m_q     <= m_d;
            k_q     <= k_d;
            m_vld_q <= m_vld_d;
            k_vld_q <= k_vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_rdy      = !k_vld_q;
    assign out_val     = m_vld_q;
    assign out_imm     = m_q.imm;
    assign out_tag     = m_q.tag;
    assign out_illegal = m_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe. A second instance with
// XLEN=64, CNT_W=2 shares the same stimulus for RV64 extension and
// counter saturation checks. Inputs change and outputs are sampled on
// the falling edge.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_val;
    logic [31:0] in_inst;
    logic [2:0]  in_imm_type;
    logic [7:0]  in_tag;
    logic        out_rdy;

    logic        in_rdy, out_val, out_illegal;
    logic [31:0] out_imm;
    logic [7:0]  out_tag;
    logic [15:0] illegal_cnt;

    logic        in_rdy_w, out_val_w, out_illegal_w;
    logic [63:0] out_imm_w;
    logic [7:0]  out_tag_w;
    logic [1:0]  illegal_cnt_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_val(in_val), .in_rdy(in_rdy),
        .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_val(out_val), .out_rdy(out_rdy),
        .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_val(in_val), .in_rdy(in_rdy_w),
        .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_val(out_val_w), .out_rdy(out_rdy),
        .out_imm(out_imm_w), .out_tag(out_tag_w), .out_illegal(out_illegal_w),
        .illegal_cnt(illegal_cnt_w)
    );

    // Present one request at a falling edge, hold through one rising edge,
    // return at the following falling edge with in_val low.
    task automatic issue(input logic [31:0] inst, input logic [2:0] t, input logic [7:0] tag);
        @(negedge clk);
        in_val      = 1'b1;
        in_inst     = inst;
        in_imm_type = t;
        in_tag      = tag;
        @(posedge clk);
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_val = 1'b0; in_inst = '0; in_imm_type = '0; in_tag = '0; out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_val !== 1'b0 || out_imm !== 32'h0 || out_tag !== 8'h0 || out_illegal !== 1'b0 || illegal_cnt !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: val=%b imm=%h tag=%h ill=%b cnt=%0d, want all zero",
                     out_val, out_imm, out_tag, out_illegal, illegal_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: in_rdy=%b out_val=%b, want 1 0", in_rdy, out_val);
        end
    endtask

    task automatic test_formats;
        logic [31:0] insts [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h00001017,
                                   32'h0080006F, 32'h123450B7, 32'h80000037, 32'h00500513};
        logic [2:0]  types [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7};
        logic [31:0] exp32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00001000,
                                   32'h00000008, 32'h12345000, 32'h80000000, 32'h00000005};
        logic [63:0] exp64 [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFFC,
                                   64'h00000000_00001000, 64'h8, 64'h00000000_12345000,
                                   64'hFFFFFFFF_80000000, 64'h5};
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(insts[i], types[i], 8'(8'h20 + i));
            n_checks++;
            if (out_val !== 1'b1 || out_imm !== exp32[i] || out_illegal !== 1'b0 || out_tag !== 8'(8'h20 + i)) begin
                n_errors++;
                $display("FAIL format_%0d: val=%b imm=%h ill=%b tag=%h, want 1 %h 0 %h",
                         i, out_val, out_imm, out_illegal, out_tag, exp32[i], 8'(8'h20 + i));
            end
            n_checks++;
            if (out_val_w !== 1'b1 || out_imm_w !== exp64[i]) begin
                n_errors++;
                $display("FAIL format64_%0d: val=%b imm=%h, want 1 %h", i, out_val_w, out_imm_w, exp64[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_val !== 1'b0) begin
            n_errors++;
            $display("FAIL format_drain: out_val=%b, want 0", out_val);
        end
    endtask

    task automatic test_illegal;
        out_rdy = 1'b1;
        issue(32'hFFF00093, 3'd5, 8'h41);
        n_checks++;
        if (out_val !== 1'b1 || out_imm !== 32'h0 || out_illegal !== 1'b1 || illegal_cnt !== 16'd1 || illegal_cnt_w !== 2'd1) begin
            n_errors++;
            $display("FAIL illegal_reserved: val=%b imm=%h ill=%b cnt=%0d cnt_w=%0d, want 1 0 1 1 1",
                     out_val, out_imm, out_illegal, illegal_cnt, illegal_cnt_w);
        end
        issue(32'h00208033, 3'd7, 8'h42);
        n_checks++;
        if (out_imm !== 32'h0 || out_illegal !== 1'b1 || illegal_cnt !== 16'd2 || out_imm_w !== 64'h0) begin
            n_errors++;
            $display("FAIL illegal_auto: imm=%h ill=%b cnt=%0d imm_w=%h, want 0 1 2 0",
                     out_imm, out_illegal, illegal_cnt, out_imm_w);
        end
        issue(32'h0, 3'd6, 8'h43);
        n_checks++;
        if (out_illegal !== 1'b1 || illegal_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL illegal_type6: ill=%b cnt=%0d, want 1 3", out_illegal, illegal_cnt);
        end
        for (int i = 0; i < 4; i++) issue(32'h0, 3'd5, 8'h44);
        n_checks++;
        if (illegal_cnt !== 16'd7 || illegal_cnt_w !== 2'd3) begin
            n_errors++;
            $display("FAIL illegal_saturate: cnt=%0d cnt_w=%0d, want 7 3", illegal_cnt, illegal_cnt_w);
        end
        issue(32'hFFF00093, 3'd0, 8'h45);
        n_checks++;
        if (out_illegal !== 1'b0 || illegal_cnt !== 16'd7 || illegal_cnt_w !== 2'd3) begin
            n_errors++;
            $display("FAIL illegal_legal_no_count: ill=%b cnt=%0d cnt_w=%0d, want 0 7 3",
                     out_illegal, illegal_cnt, illegal_cnt_w);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_rdy = 1'b0;
        in_val = 1'b1; in_inst = 32'h00100093; in_imm_type = 3'd0; in_tag = 8'd1;
        @(negedge clk);
        in_tag = 8'd2; in_inst = 32'h00200093;
        @(negedge clk);
        n_checks++;
        if (in_rdy !== 1'b0 || out_val !== 1'b1 || out_tag !== 8'd1) begin
            n_errors++;
            $display("FAIL bp_full: in_rdy=%b val=%b tag=%0d, want 0 1 1", in_rdy, out_val, out_tag);
        end
        in_tag = 8'd3; in_inst = 32'h00300093;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_rdy !== 1'b0 || out_tag !== 8'd1 || out_imm !== 32'd1) begin
            n_errors++;
            $display("FAIL bp_hold: in_rdy=%b tag=%0d imm=%h, want 0 1 1", in_rdy, out_tag, out_imm);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_val !== 1'b1 || out_tag !== 8'd2 || out_imm !== 32'd2 || in_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_second: val=%b tag=%0d imm=%h in_rdy=%b, want 1 2 2 1", out_val, out_tag, out_imm, in_rdy);
        end
        @(negedge clk);
        in_val = 1'b0;
        n_checks++;
        if (out_val !== 1'b1 || out_tag !== 8'd3 || out_imm !== 32'd3) begin
            n_errors++;
            $display("FAIL bp_third: val=%b tag=%0d imm=%h, want 1 3 3", out_val, out_tag, out_imm);
        end
        @(negedge clk);
        n_checks++;
        if (out_val !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_empty: out_val=%b, want 0", out_val);
        end
    endtask

    task automatic test_back_to_back;
        out_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            in_val = (i < 5); in_imm_type = 3'd0;
            in_inst = {12'(i + 16), 20'h00093}; in_tag = 8'(8'd10 + i);
            @(negedge clk);
            if (i < 5) begin
                n_checks++;
                if (out_val !== 1'b1 || out_tag !== 8'(8'd10 + i) || out_imm !== 32'(i + 16) || in_rdy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_%0d: val=%b tag=%0d imm=%h in_rdy=%b, want 1 %0d %h 1",
                             i, out_val, out_tag, out_imm, in_rdy, 10 + i, 32'(i + 16));
                end
            end
        end
        n_checks++;
        if (out_val !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_empty: out_val=%b, want 0", out_val);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        out_rdy = 1'b0;
        in_val = 1'b1; in_inst = 32'h0; in_imm_type = 3'd5; in_tag = 8'h77;
        repeat (2) @(negedge clk);
        in_val = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_val !== 1'b0 || illegal_cnt !== 16'd0 || illegal_cnt_w !== 2'd0 || in_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid: val=%b cnt=%0d cnt_w=%0d in_rdy=%b, want 0 0 0 1",
                     out_val, illegal_cnt, illegal_cnt_w, in_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_val !== 1'b0 || in_rdy !== 1'b1 || out_val_w !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_stale_%0d: val=%b in_rdy=%b val_w=%b, want 0 1 0",
                         i, out_val, in_rdy, out_val_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
